inst_sequencer: RTL and testbench
=================================

Name: inst_sequencer

Overview:
Multi-cycle control FSM that sequences the CPU around the combinational instruction decoder. It fetches a 32-bit word from instruction ROM, holds it in an instruction register that drives the decoder, and stalls on MUL/DIV and on RAM accesses. It then issues single-cycle register-writeback and PC-update strobes, and services WAIT and external interrupt requests. It sits between the fetch/RAM handshakes and the decoder, register-file and PC enables.

Parameters:
ALU_TIMEOUT, 32, maximum cycles in ALU_WAIT before the block forces progress and sets err_o.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_n_i  in  1  reset, asynchronous assert, active-low.
fetch_req_o  out  1  instruction fetch request, held until acknowledged.
fetch_ack_i  in  1  ROM data valid on inst_i this cycle.
inst_i  in  32  instruction word from ROM.
inst_o  out  32  instruction register, drives the decoder.
alu_op_i  in  8  opcode from the decoder (inst_o[31:24]).
pc_i  in  2  PC-mode field from the decoder.
reg_i  in  2  register-write field from the decoder; non-zero means write.
mem_i  in  1  memory-access flag from the decoder.
alu_start_o  out  1  single-cycle start pulse for a multi-cycle MUL/DIV.
alu_done_i  in  1  multi-cycle ALU result ready.
mem_req_o  out  1  RAM request, held until acknowledged.
mem_we_o  out  1  RAM write enable; valid while mem_req_o is high.
mem_ack_i  in  1  RAM access complete.
reg_we_o  out  1  register-file write strobe.
pc_upd_o  out  1  PC load/increment strobe.
pc_sel_o  out  2  PC mode applied with pc_upd_o.
irq_i  in  1  level interrupt request.
irq_ack_o  out  1  interrupt acknowledge, single-cycle pulse.
int_vec_o  out  1  qualifies pc_upd_o as a load of the interrupt vector.
busy_o  out  1  high in every state except IDLE and HALT.
err_o  out  1  sticky ALU-timeout flag.
state_o  out  3  current FSM state encoding, for debug.
inst_cnt_o  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (asynchronous, rst_n_i low): state IDLE; inst_o=0; inst_cnt_o=0; timeout counter=0; all strobes, requests, err_o and int_vec_o at 0; pc_sel_o=0. Reset mid-handshake abandons the handshake; requests drop in the same cycle reset asserts.
- Registered FSM. All outputs are Moore outputs decoded from the state register.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, ALU_WAIT=4, MEM=5, WB=6, HALT=7.
- IDLE: one cycle after reset deasserts, then FETCH.
- FETCH: fetch_req_o=1. On fetch_ack_i, capture inst_o<=inst_i and go to DECODE.
- DECODE: one cycle for decoder outputs to settle. Then EXEC.
- EXEC:
  - alu_op_i==MUL or DIV: alu_start_o=1 this cycle, clear the timeout counter, go to ALU_WAIT.
  - alu_op_i==WAIT: go to HALT.
  - otherwise: go to MEM if mem_i=1, else WB.
- ALU_WAIT: counter increments each cycle.
  - On alu_done_i: go to MEM if mem_i=1, else WB.
  - When the counter reaches ALU_TIMEOUT-1 without alu_done_i: set err_o, go to WB.
  - alu_done_i on the timeout cycle counts as done; err_o is not set.
- MEM: mem_req_o=1; mem_we_o=1 only if alu_op_i==MOVEIN. On mem_ack_i go to WB.
- WB:
  - reg_we_o=(reg_i!=0); pc_upd_o=1; pc_sel_o=pc_i; inst_cnt_o increments, wrapping from all-ones to 0.
  - If irq_i=1: irq_ack_o=1, int_vec_o=1 (overrides pc_sel_o). Then FETCH.
- HALT: busy_o=0, no strobes while waiting. When irq_i=1, go to WB. A WAIT instruction is retired only on wake.
- irq_i is sampled only in WB and HALT. An interrupt arriving mid-instruction is deferred to that instruction's WB.
- Only one of fetch_req_o/mem_req_o is ever high; strobes never coincide with a request.
- ack inputs arriving outside the matching request state are ignored.

Decomposition:
- Opcode constants (MUL, DIV, WAIT, MOVEIN), the state encodings and the PC-mode codes belong in the shared defs include.
- One sub-module is natural: seq_timeout_cnt, the ALU_TIMEOUT counter with clear, enable and expired outputs.

Test Plan:
1. ADD register form, mem_i=0, reg_i=1; fetch_ack_i 2 cycles after request -> FETCH, DECODE, EXEC, WB; reg_we_o and pc_upd_o pulse once; inst_cnt_o=1.
2. MOVEIN with mem_i=1; mem_ack_i after 3 cycles -> mem_req_o high 3 cycles with mem_we_o=1, then WB; a MOVEOUT repeat gives mem_we_o=0.
3. DIV with alu_done_i after 5 cycles -> alu_start_o single pulse, 5 cycles in ALU_WAIT, err_o=0; with alu_done_i never asserted -> after 32 cycles err_o=1 (sticky) and WB occurs.
4. WAIT -> state_o=7, busy_o=0 indefinitely; raise irq_i -> WB with irq_ack_o=1, int_vec_o=1; inst_cnt_o increments.
5. irq_i raised during FETCH of an ADD -> ADD completes normally; irq_ack_o occurs only in its WB.
6. rst_n_i pulled low during MEM with mem_req_o high -> mem_req_o and all outputs 0 immediately; after release, IDLE then FETCH; inst_cnt_o=0.

Source files
------------

// File: rtl/inst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_sequencer_pkg
// Description : Shared state encodings, opcodes and PC-mode codes for the
//               instruction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_ALU_WAIT = 3'd4,
        ST_MEM      = 3'd5,
        ST_WB       = 3'd6,
        ST_HALT     = 3'd7
    } state_t;

    typedef enum logic [7:0] {
        OP_ADD     = 8'h01,
        OP_SUB     = 8'h02,
        OP_MUL     = 8'h10,
        OP_DIV     = 8'h11,
        OP_MOVEIN  = 8'h20,
        OP_MOVEOUT = 8'h21,
        OP_WAIT    = 8'hF0
    } opcode_t;

    typedef enum logic [1:0] {
        PC_INC    = 2'd0,
        PC_JUMP   = 2'd1,
        PC_BRANCH = 2'd2,
        PC_RETURN = 2'd3
    } pc_mode_t;

    function automatic logic is_multicycle(input logic [7:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_sequencer_if
// Description : Fetch/RAM/ALU handshakes, decoder fields and control strobes
//               between the sequencer (master) and the rest of the core.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_sequencer_if #(
    parameter int CNT_W = 16
) ();
    import inst_sequencer_pkg::*;

    logic             fetch_req_o;
    logic             fetch_ack_i;
    logic [31:0]      inst_i;
    logic [31:0]      inst_o;
    logic [7:0]       alu_op_i;
    logic [1:0]       pc_i;
    logic [1:0]       reg_i;
    logic             mem_i;
    logic             alu_start_o;
    logic             alu_done_i;
    logic             mem_req_o;
    logic             mem_we_o;
    logic             mem_ack_i;
    logic             reg_we_o;
    logic             pc_upd_o;
    logic [1:0]       pc_sel_o;
    logic             irq_i;
    logic             irq_ack_o;
    logic             int_vec_o;
    logic             busy_o;
    logic             err_o;
    state_t           state_o;
    logic [CNT_W-1:0] inst_cnt_o;

    modport master (
        output fetch_req_o, inst_o, alu_start_o, mem_req_o, mem_we_o,
               reg_we_o, pc_upd_o, pc_sel_o, irq_ack_o, int_vec_o,
               busy_o, err_o, state_o, inst_cnt_o,
        input  fetch_ack_i, inst_i, alu_op_i, pc_i, reg_i, mem_i,
               alu_done_i, mem_ack_i, irq_i
    );

    modport slave (
        input  fetch_req_o, inst_o, alu_start_o, mem_req_o, mem_we_o,
               reg_we_o, pc_upd_o, pc_sel_o, irq_ack_o, int_vec_o,
               busy_o, err_o, state_o, inst_cnt_o,
        output fetch_ack_i, inst_i, alu_op_i, pc_i, reg_i, mem_i,
               alu_done_i, mem_ack_i, irq_i
    );

endinterface
`default_nettype wire

// File: rtl/inst_sequencer_seq_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : inst_sequencer_seq_timeout_cnt
// Description : Cycle counter bounding the multi-cycle ALU wait.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_sequencer_seq_timeout_cnt #(
    parameter int ALU_TIMEOUT = 32
) (
    input  wire logic clk_i,
    input  wire logic rst_n_i,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      expired_o
);

    localparam int                c_cnt_w = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(ALU_TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired_o = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : inst_sequencer
// Description : Multi-cycle fetch/decode/execute/writeback control FSM with
//               ALU and RAM stalls, WAIT halt and interrupt servicing.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int ALU_TIMEOUT = 32,
    parameter int CNT_W       = 16
) (
    input  wire logic          clk_i,
    input  wire logic          rst_n_i,
    inst_sequencer_if.master   bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_inst;
    logic [CNT_W-1:0] r_inst_cnt;
    logic             r_fetch_req;
    logic             r_mem_req;
    logic             r_mem_we;
    logic             r_alu_start;
    logic             r_reg_we;
    logic             r_pc_upd;
    logic [1:0]       r_pc_sel;
    logic             r_irq_ack;
    logic             r_int_vec;
    logic             r_busy;
    logic             r_err;
    logic             w_expired;
    logic             w_timeout;

    inst_sequencer_seq_timeout_cnt #(
        .ALU_TIMEOUT (ALU_TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (r_state == ST_EXEC),
        .en_i      (r_state == ST_ALU_WAIT),
        .expired_o (w_expired)
    );

    // A done on the expiry cycle wins, so no error is flagged then.
    assign w_timeout = (r_state == ST_ALU_WAIT) && !bus.alu_done_i && w_expired;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     w_state_nxt = ST_FETCH;
            ST_FETCH:    if (bus.fetch_ack_i) w_state_nxt = ST_DECODE;
            ST_DECODE:   w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (is_multicycle(bus.alu_op_i))  w_state_nxt = ST_ALU_WAIT;
                else if (bus.alu_op_i == OP_WAIT) w_state_nxt = ST_HALT;
                else if (bus.mem_i)               w_state_nxt = ST_MEM;
                else                              w_state_nxt = ST_WB;
            end
            ST_ALU_WAIT: begin
                if (bus.alu_done_i) w_state_nxt = bus.mem_i ? ST_MEM : ST_WB;
                else if (w_expired) w_state_nxt = ST_WB;
            end
            ST_MEM:      if (bus.mem_ack_i) w_state_nxt = ST_WB;
            ST_WB:       w_state_nxt = ST_FETCH;
            ST_HALT:     if (bus.irq_i) w_state_nxt = ST_WB;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_o.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_inst      <= '0;
            r_inst_cnt  <= '0;
            r_fetch_req <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_alu_start <= 1'b0;
            r_reg_we    <= 1'b0;
            r_pc_upd    <= 1'b0;
            r_pc_sel    <= PC_INC;
            r_irq_ack   <= 1'b0;
            r_int_vec   <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_FETCH && bus.fetch_ack_i) r_inst <= bus.inst_i;
            if (r_state == ST_WB) r_inst_cnt <= r_inst_cnt + 1'b1;
            if (w_timeout) r_err <= 1'b1;

            r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_HALT);
            r_fetch_req <= (w_state_nxt == ST_FETCH);
            r_mem_req   <= (w_state_nxt == ST_MEM);
            r_mem_we    <= (w_state_nxt == ST_MEM) && (bus.alu_op_i == OP_MOVEIN);
            r_alu_start <= (w_state_nxt == ST_EXEC) && is_multicycle(bus.alu_op_i);
            r_reg_we    <= (w_state_nxt == ST_WB) && (bus.reg_i != 2'd0);
            r_pc_upd    <= (w_state_nxt == ST_WB);
            r_pc_sel    <= (w_state_nxt == ST_WB) ? bus.pc_i : PC_INC;
            r_irq_ack   <= (w_state_nxt == ST_WB) && bus.irq_i;
            r_int_vec   <= (w_state_nxt == ST_WB) && bus.irq_i;
        end
    end

    assign bus.state_o     = r_state;
    assign bus.inst_o      = r_inst;
    assign bus.inst_cnt_o  = r_inst_cnt;
    assign bus.fetch_req_o = r_fetch_req;
    assign bus.mem_req_o   = r_mem_req;
    assign bus.mem_we_o    = r_mem_we;
    assign bus.alu_start_o = r_alu_start;
    assign bus.reg_we_o    = r_reg_we;
    assign bus.pc_upd_o    = r_pc_upd;
    assign bus.pc_sel_o    = r_pc_sel;
    assign bus.irq_ack_o   = r_irq_ack;
    assign bus.int_vec_o   = r_int_vec;
    assign bus.busy_o      = r_busy;
    assign bus.err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_sequencer
// Description : Self-checking bench: instruction-level reference model with
//               randomized latencies, fields, ack noise and interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_sequencer;
    import inst_sequencer_pkg::*;

    localparam int ALU_TIMEOUT = 32;
    localparam int CNT_W       = 16;
    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3,
                   S_ALU_WAIT = 4, S_MEM = 5, S_WB = 6, S_HALT = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    inst_sequencer_if #(.CNT_W(CNT_W)) bus ();

    inst_sequencer #(
        .ALU_TIMEOUT (ALU_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the instruction currently in flight plus architectural state.
    logic [7:0]       m_op  = 8'h00;
    logic [1:0]       m_pc  = 2'd0;
    logic [1:0]       m_reg = 2'd0;
    logic             m_irq = 1'b0;
    logic             m_err = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] got_ctrl();
        return {bus.busy_o, bus.fetch_req_o, bus.mem_req_o, bus.mem_we_o, bus.alu_start_o,
                bus.reg_we_o, bus.pc_upd_o, bus.pc_sel_o, bus.irq_ack_o, bus.int_vec_o, bus.err_o};
    endfunction

    function automatic logic [11:0] exp_ctrl(input int st);
        logic       wb = (st == S_WB);
        logic       muldiv = (m_op == OP_MUL) || (m_op == OP_DIV);
        logic [1:0] sel = wb ? m_pc : 2'd0;
        return {(st != S_IDLE) && (st != S_HALT), st == S_FETCH, st == S_MEM,
                (st == S_MEM) && (m_op == OP_MOVEIN), (st == S_EXEC) && muldiv,
                wb && (m_reg != 2'd0), wb, sel, wb && m_irq, wb && m_irq, m_err};
    endfunction

    task automatic step(input int st, input string tag);
        @(posedge clk);
        #1;
        check_eq({tag, ".state"}, 32'(bus.state_o), 32'(st));
        check_eq({tag, ".ctrl"}, 32'(got_ctrl()), 32'(exp_ctrl(st)));
        check_eq({tag, ".cnt"}, 32'(bus.inst_cnt_o), 32'(m_cnt));
    endtask

    // Acks outside their request state must be ignored, so toggle them freely.
    task automatic noise();
        bus.fetch_ack_i = 1'($urandom_range(0, 1));
        bus.mem_ack_i   = 1'($urandom_range(0, 1));
        bus.alu_done_i  = 1'($urandom_range(0, 1));
        bus.inst_i      = $urandom;
    endtask

    task automatic apply_reset();
        bus.fetch_ack_i = 1'b0; bus.mem_ack_i = 1'b0; bus.alu_done_i = 1'b0;
        bus.inst_i = '0; bus.alu_op_i = '0; bus.pc_i = '0; bus.reg_i = '0;
        bus.mem_i = 1'b0; bus.irq_i = 1'b0;
        rst_n = 1'b0;
        m_err = 1'b0; m_cnt = '0; m_irq = 1'b0; m_op = 8'h00; m_pc = 2'd0; m_reg = 2'd0;
        #1;
        check_eq("rst.state", 32'(bus.state_o), 32'(S_IDLE));
        check_eq("rst.ctrl", 32'(got_ctrl()), 32'd0);
        check_eq("rst.cnt", 32'(bus.inst_cnt_o), 32'd0);
        check_eq("rst.inst", bus.inst_o, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rel.state", 32'(bus.state_o), 32'(S_IDLE));
        check_eq("rel.ctrl", 32'(got_ctrl()), 32'd0);
    endtask

    // alat: cycle of alu_done within ALU_WAIT (1-based), 0 = never.
    task automatic run_instr(input logic [7:0] op, input logic [1:0] pc, input logic [1:0] rg,
                             input logic mem, input int flat, input int alat, input int mlat,
                             input int halt_cyc, input logic irq, input int rst_at_mem);
        logic [31:0] word = {op, 24'($urandom)};
        logic        to_mem = mem;
        m_irq     = irq;
        bus.irq_i = irq;
        for (int k = 0; k <= flat; k++) begin
            step(S_FETCH, "fetch");
            noise();
            bus.fetch_ack_i = (k == flat);
            if (k == flat) bus.inst_i = word;
        end
        step(S_DECODE, "decode");
        check_eq("decode.inst_o", bus.inst_o, word);
        noise();
        bus.alu_op_i = op; bus.pc_i = pc; bus.reg_i = rg; bus.mem_i = mem;
        m_op = op; m_pc = pc; m_reg = rg;
        step(S_EXEC, "exec");
        noise();
        if (op == OP_WAIT) begin
            to_mem = 1'b0;
            for (int h = 0; h < halt_cyc; h++) begin
                step(S_HALT, "halt");
                noise();
                bus.irq_i = (h == halt_cyc - 1);
            end
            m_irq = 1'b1;
        end else if (op == OP_MUL || op == OP_DIV) begin
            for (int k = 0; k < ALU_TIMEOUT; k++) begin
                step(S_ALU_WAIT, "aluwait");
                noise();
                bus.alu_done_i = (k == alat - 1);
                if (k == alat - 1) break;
            end
            if (alat == 0) begin
                m_err  = 1'b1;
                to_mem = 1'b0;
            end
        end
        if (to_mem) begin
            for (int k = 0; k <= mlat; k++) begin
                step(S_MEM, "mem");
                noise();
                bus.mem_ack_i = (k == mlat);
                if (k == rst_at_mem) begin
                    apply_reset();
                    return;
                end
            end
        end
        step(S_WB, "wb");
        noise();
        bus.irq_i = 1'b0;
        m_cnt = m_cnt + 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops [7];
        ops = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOVEIN, OP_MOVEOUT, OP_WAIT};
        bus.fetch_ack_i = 1'b0; bus.mem_ack_i = 1'b0; bus.alu_done_i = 1'b0;
        bus.inst_i = '0; bus.alu_op_i = '0; bus.pc_i = '0; bus.reg_i = '0;
        bus.mem_i = 1'b0; bus.irq_i = 1'b0;
        #2;
        apply_reset();

        run_instr(OP_ADD,     PC_INC,    2'd1, 1'b0, 2, 0,  0, 0, 1'b0, -1);
        run_instr(OP_MOVEIN,  PC_INC,    2'd2, 1'b1, 0, 0,  2, 0, 1'b0, -1);
        run_instr(OP_MOVEOUT, PC_JUMP,   2'd0, 1'b1, 1, 0,  2, 0, 1'b0, -1);
        run_instr(OP_DIV,     PC_INC,    2'd3, 1'b0, 0, 5,  0, 0, 1'b0, -1);
        run_instr(OP_DIV,     PC_BRANCH, 2'd1, 1'b1, 0, 0,  0, 0, 1'b0, -1);
        run_instr(OP_ADD,     PC_INC,    2'd1, 1'b0, 0, 0,  0, 0, 1'b0, -1);
        run_instr(OP_WAIT,    PC_JUMP,   2'd2, 1'b0, 1, 0,  0, 8, 1'b0, -1);
        run_instr(OP_ADD,     PC_BRANCH, 2'd1, 1'b0, 3, 0,  0, 0, 1'b1, -1);
        run_instr(OP_MOVEIN,  PC_INC,    2'd1, 1'b1, 0, 0,  5, 0, 1'b0, 1);
        run_instr(OP_MUL,     PC_RETURN, 2'd1, 1'b1, 0, 32, 1, 0, 1'b0, -1);
        run_instr(OP_MUL,     PC_INC,    2'd0, 1'b0, 0, 31, 0, 0, 1'b1, -1);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] op = ops[$urandom_range(0, 6)];
            int         sel = $urandom_range(0, 9);
            int         alat = (sel == 0) ? 0 : (sel == 1) ? ALU_TIMEOUT : $urandom_range(1, 8);
            logic       irq = (op != OP_WAIT) && ($urandom_range(0, 2) == 0);
            run_instr(op, 2'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 3),
                      alat, $urandom_range(0, 3), $urandom_range(1, 4), irq, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
